// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter with a valid/ready load port and a downstream
// advance strobe; back-to-back words stream with no idle bit between them.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             accept;

  // Output bit comes straight from the register end, gated to 0 outside SHIFT.
  assign busy       = (state == SHIFT);
  assign dout_valid = busy;
  assign dout_last  = busy && (cnt == LAST_IDX);
  assign load_ready = (state == IDLE) || (dout_last && shift_en);
  assign accept     = load_valid && load_ready;
  assign dout       = busy ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : 1'b0;

  // Next-state logic: a load always wins, which gives gapless streaming on the last bit.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          sreg_nxt  = data_in;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (accept) begin
          state_nxt = SHIFT;
          sreg_nxt  = data_in;
          cnt_nxt   = '0;
        end else if (shift_en && !dout_last) begin
          sreg_nxt = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
          cnt_nxt  = cnt + ONE;
        end else if (shift_en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = SHIFT;
        end
      end
      default: begin
        state_nxt = IDLE;
        sreg_nxt  = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule
